// File: rtl/obi_addr_demux.sv
// OBI address demultiplexer: one manager port fanned out to NumSbr subordinate
// ports by an address rule table. Port 0 is an internal error subordinate that
// answers every unmapped access with an error response.
module obi_addr_demux #(
    parameter int unsigned NumSbr    = 4,
    parameter int unsigned NumRules  = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned MaxTrans  = 4,
    parameter logic [NumRules-1:0][31:0] RuleIdx =
        {32'd3, 32'd2, 32'd1, 32'd1},
    parameter logic [NumRules-1:0][AddrWidth-1:0] RuleStart =
        {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [NumRules-1:0][AddrWidth-1:0] RuleEnd =
        {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000}
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    // manager side
    input  logic                        mgr_req_i,
    input  logic [AddrWidth-1:0]        mgr_addr_i,
    input  logic                        mgr_we_i,
    input  logic [DataWidth/8-1:0]      mgr_be_i,
    input  logic [DataWidth-1:0]        mgr_wdata_i,
    input  logic [IdWidth-1:0]          mgr_aid_i,
    output logic                        mgr_gnt_o,
    output logic                        mgr_rvalid_o,
    output logic [DataWidth-1:0]        mgr_rdata_o,
    output logic [IdWidth-1:0]          mgr_rid_o,
    output logic                        mgr_err_o,
    // subordinate side
    output logic [NumSbr-1:0]           sbr_req_o,
    output logic [AddrWidth-1:0]        sbr_addr_o,
    output logic                        sbr_we_o,
    output logic [DataWidth/8-1:0]      sbr_be_o,
    output logic [DataWidth-1:0]        sbr_wdata_o,
    output logic [IdWidth-1:0]          sbr_aid_o,
    input  logic [NumSbr-1:0]           sbr_gnt_i,
    input  logic [NumSbr-1:0]           sbr_rvalid_i,
    input  logic [NumSbr*DataWidth-1:0] sbr_rdata_i,
    input  logic [NumSbr*IdWidth-1:0]   sbr_rid_i,
    input  logic [NumSbr-1:0]           sbr_err_i
);

    localparam int unsigned SelW = (NumSbr > 1) ? $clog2(NumSbr) : 1;
    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam logic [DataWidth-1:0] ErrData = DataWidth'(32'hBADCAB1E);

    logic [SelW-1:0]    sel, tgt_q, tgt_d;
    logic [CntW-1:0]    cnt_q, cnt_d, cnt_eff;
    logic               stall, accept;

    logic [IdWidth-1:0] err_aid_q [MaxTrans];
    logic [PtrW-1:0]    err_wr_q, err_wr_d, err_rd_q, err_rd_d;
    logic [CntW-1:0]    err_cnt_q, err_cnt_d;
    logic               err_push, err_pop;

    // Port 0 is internal, so its external inputs are intentionally unused.
    logic unused_port0;
    assign unused_port0 = ^{sbr_gnt_i[0], sbr_rvalid_i[0], sbr_rdata_i[DataWidth-1:0],
                            sbr_rid_i[IdWidth-1:0], sbr_err_i[0]};

    // Address decode: first (lowest-index) matching rule wins, no match -> error port.
    always_comb begin
        logic hit;
        hit = 1'b0;
        sel = '0;
        for (int r = 0; r < NumRules; r++) begin
            if (!hit && mgr_addr_i >= RuleStart[r] && mgr_addr_i < RuleEnd[r]) begin
                sel = RuleIdx[r][SelW-1:0];
                hit = 1'b1;
            end
        end
    end

    // A-channel broadcast.
    assign sbr_addr_o  = mgr_addr_i;
    assign sbr_we_o    = mgr_we_i;
    assign sbr_be_o    = mgr_be_i;
    assign sbr_wdata_o = mgr_wdata_i;
    assign sbr_aid_o   = mgr_aid_i;

    // Response mux from the tracked target; silent while nothing is outstanding.
    always_comb begin
        mgr_rvalid_o = 1'b0;
        mgr_rdata_o  = '0;
        mgr_rid_o    = '0;
        mgr_err_o    = 1'b0;
        if (cnt_q != '0) begin
            if (tgt_q == '0) begin
                mgr_rvalid_o = (err_cnt_q != '0);
                mgr_rdata_o  = ErrData;
                mgr_rid_o    = err_aid_q[err_rd_q];
                mgr_err_o    = 1'b1;
            end else begin
                mgr_rvalid_o = sbr_rvalid_i[tgt_q];
                mgr_rdata_o  = sbr_rdata_i[tgt_q*DataWidth +: DataWidth];
                mgr_rid_o    = sbr_rid_i[tgt_q*IdWidth +: IdWidth];
                mgr_err_o    = sbr_err_i[tgt_q];
            end
        end
    end

    // Stall uses the count net of a response retiring this cycle, so a request
    // to a new target can be granted in the same cycle the last response returns.
    always_comb begin
        cnt_eff   = cnt_q - CntW'(mgr_rvalid_o);
        stall     = (cnt_eff == CntW'(MaxTrans)) || (cnt_eff != '0 && sel != tgt_q);
        mgr_gnt_o = !stall && ((sel == '0) || sbr_gnt_i[sel]);
        sbr_req_o = '0;
        if (sel != '0) sbr_req_o[sel] = mgr_req_i & ~stall;
        accept    = mgr_req_i & mgr_gnt_o;
    end

    // Outstanding counter and target tracking next state.
    always_comb begin
        cnt_d = cnt_q;
        case ({accept, mgr_rvalid_o})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        tgt_d = accept ? sel : tgt_q;
    end

    // Error-subordinate FIFO next state: push on accepted unmapped request, pop on response.
    always_comb begin
        err_push  = accept && (sel == '0);
        err_pop   = mgr_rvalid_o && (tgt_q == '0);
        err_wr_d  = err_wr_q;
        err_rd_d  = err_rd_q;
        err_cnt_d = err_cnt_q;
        if (err_push) err_wr_d = (err_wr_q == PtrW'(MaxTrans - 1)) ? '0 : err_wr_q + 1'b1;
        if (err_pop)  err_rd_d = (err_rd_q == PtrW'(MaxTrans - 1)) ? '0 : err_rd_q + 1'b1;
        if (err_push && !err_pop)      err_cnt_d = err_cnt_q + 1'b1;
        else if (!err_push && err_pop) err_cnt_d = err_cnt_q - 1'b1;
    end

    // Tracking and error-FIFO state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            tgt_q     <= '0;
            err_wr_q  <= '0;
            err_rd_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            err_wr_q  <= err_wr_d;
            err_rd_q  <= err_rd_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Error FIFO payload: only the request ID needs storing.
    always_ff @(posedge clk_i) begin
        if (err_push) err_aid_q[err_wr_q] <= mgr_aid_i;
    end

    // Configuration sanity checks.
    for (genvar r = 0; r < NumRules; r++) begin : g_rule_chk
        assert property (@(posedge clk_i) RuleStart[r] < RuleEnd[r]);
        assert property (@(posedge clk_i) RuleIdx[r] >= 1 && RuleIdx[r] < NumSbr);
    end
    assert property (@(posedge clk_i) MaxTrans >= 1);

endmodule

// File: tb/tb_obi_addr_demux.sv
// Scoreboard bench for obi_addr_demux: a driver with a transaction-level model
// issues requests and subordinate responses, a monitor checks every response.
module tb_obi_addr_demux;

    localparam int MT = 2;
    localparam logic [3:0][31:0] RI = {32'd3, 32'd2, 32'd2, 32'd1};
    localparam logic [3:0][31:0] RS = {32'h2000_0000, 32'h1000_0000, 32'h0, 32'h0};
    localparam logic [3:0][31:0] RE = {32'h2000_1000, 32'h1000_0200, 32'h200, 32'h100};

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        rid;
        logic        err;
        int          acc;
    } ent_t;

    logic         clk = 1'b0, rst_n;
    logic         mgr_req_i, mgr_we_i, mgr_gnt_o, mgr_rvalid_o, mgr_err_o;
    logic [31:0]  mgr_addr_i, mgr_wdata_i, mgr_rdata_o;
    logic [3:0]   mgr_be_i;
    logic         mgr_aid_i, mgr_rid_o;
    logic [3:0]   sbr_req_o, sbr_be_o, sbr_gnt_i, sbr_rvalid_i, sbr_rid_i, sbr_err_i;
    logic [31:0]  sbr_addr_o, sbr_wdata_o;
    logic         sbr_we_o, sbr_aid_o;
    logic [127:0] sbr_rdata_i;

    ent_t outst[$];   // transactions the subordinate models still owe
    ent_t exp_q[$];   // responses the manager should see, in order
    int   n_chk = 0, n_err = 0, cyc = 0;
    logic [31:0] atab [10];

    always #5 clk = ~clk;

    obi_addr_demux #(
        .NumSbr(4), .NumRules(4), .AddrWidth(32), .DataWidth(32), .IdWidth(1),
        .MaxTrans(MT), .RuleIdx(RI), .RuleStart(RS), .RuleEnd(RE)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mgr_req_i(mgr_req_i), .mgr_addr_i(mgr_addr_i), .mgr_we_i(mgr_we_i),
        .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i), .mgr_aid_i(mgr_aid_i),
        .mgr_gnt_o(mgr_gnt_o), .mgr_rvalid_o(mgr_rvalid_o), .mgr_rdata_o(mgr_rdata_o),
        .mgr_rid_o(mgr_rid_o), .mgr_err_o(mgr_err_o),
        .sbr_req_o(sbr_req_o), .sbr_addr_o(sbr_addr_o), .sbr_we_o(sbr_we_o),
        .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o), .sbr_aid_o(sbr_aid_o),
        .sbr_gnt_i(sbr_gnt_i), .sbr_rvalid_i(sbr_rvalid_i), .sbr_rdata_i(sbr_rdata_i),
        .sbr_rid_i(sbr_rid_i), .sbr_err_i(sbr_err_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Rule table lookup: first rule containing the address, else the error port.
    function automatic int dec(input logic [31:0] a);
        for (int r = 0; r < 4; r++)
            if (a >= RS[r] && a < RE[r]) return int'(RI[r]);
        return 0;
    endfunction

    // One clock cycle: drive inputs, predict grant/request/response, update model.
    task automatic cycle(input bit req, input logic [31:0] addr, input bit aid,
                         input logic [3:0] gnt, input bit resp_ok, output bit acc);
        ent_t h, e;
        bit rnow, stall, eg;
        int sel, busy, n_after;
        logic [3:0] noise, ereq;
        logic [31:0] wd;
        rnow  = 1'b0;
        noise = 4'($urandom);
        h     = '{port: 0, rdata: 0, rid: 0, err: 0, acc: 0};
        if (outst.size() > 0) begin
            h = outst[0];
            if (h.port == 0) rnow = 1'b1;
            else begin
                noise[h.port] = 1'b0;
                if (resp_ok && cyc > h.acc) rnow = 1'b1;
            end
        end
        wd           = $urandom;
        mgr_req_i    = req;
        mgr_addr_i   = addr;
        mgr_we_i     = 1'($urandom);
        mgr_be_i     = 4'($urandom);
        mgr_wdata_i  = wd;
        mgr_aid_i    = aid;
        sbr_gnt_i    = gnt;
        sbr_rvalid_i = noise;
        sbr_rdata_i  = {$urandom, $urandom, $urandom, $urandom};
        sbr_rid_i    = 4'($urandom);
        sbr_err_i    = 4'($urandom);
        if (rnow && h.port != 0) begin
            sbr_rvalid_i[h.port]          = 1'b1;
            sbr_rdata_i[h.port*32 +: 32]  = h.rdata;
            sbr_rid_i[h.port]             = h.rid;
            sbr_err_i[h.port]             = h.err;
        end
        #3;
        sel     = dec(addr);
        n_after = outst.size() - int'(rnow);
        busy    = (outst.size() > 0) ? outst[0].port : 0;
        stall   = (n_after == MT) || (n_after > 0 && sel != busy);
        eg      = !stall && (sel == 0 || gnt[sel]);
        ereq    = '0;
        if (sel != 0 && req && !stall) ereq[sel] = 1'b1;
        chk("gnt",    32'(mgr_gnt_o),    32'(eg));
        chk("req",    32'(sbr_req_o),    32'(ereq));
        chk("rvalid", 32'(mgr_rvalid_o), 32'(rnow));
        chk("addr",   sbr_addr_o,        addr);
        chk("wdata",  sbr_wdata_o,       wd);
        acc = req && eg;
        if (rnow) void'(outst.pop_front());
        if (acc) begin
            e.port = sel;
            e.acc  = cyc;
            e.rid  = aid;
            if (sel == 0) begin
                e.rdata = 32'hBADCAB1E;
                e.err   = 1'b1;
            end else begin
                e.rdata = $urandom;
                e.err   = ($urandom_range(0, 3) == 0);
            end
            outst.push_back(e);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold a request until granted, bounded.
    task automatic send(input logic [31:0] addr, input bit aid, input bit resp_ok);
        bit a;
        a = 1'b0;
        for (int i = 0; i < 20 && !a; i++) cycle(1'b1, addr, aid, 4'hF, resp_ok, a);
        if (!a) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 60 && outst.size() > 0; i++) cycle(1'b0, 32'h0, 1'b0, 4'hF, 1'b1, a);
    endtask

    // Monitor: every manager response must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (mgr_rvalid_o === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("rdata", mgr_rdata_o,      e.rdata);
                    chk("rid",   32'(mgr_rid_o),   32'(e.rid));
                    chk("err",   32'(mgr_err_o),   32'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit a;
        atab = '{32'h80, 32'hFF, 32'h100, 32'h1FF, 32'h200, 32'h0FFF_FFFF,
                 32'h1000_0000, 32'h1000_01FF, 32'h1000_0200, 32'h2000_0FFF};
        rst_n = 1'b0;
        mgr_req_i = 0; mgr_addr_i = 0; mgr_we_i = 0; mgr_be_i = 0; mgr_wdata_i = 0;
        mgr_aid_i = 0; sbr_gnt_i = 0; sbr_rvalid_i = 4'hF; sbr_rdata_i = '1;
        sbr_rid_i = '1; sbr_err_i = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", 32'(mgr_rvalid_o), 32'd0);
        chk("rst_req",    32'(sbr_req_o),    32'd0);
        rst_n = 1'b1;

        // Mapped read to port 2, response carries its rid.
        cycle(1'b1, 32'h1000_0004, 1'b1, 4'hF, 1'b1, a);
        chk("req033_acc", 32'(a), 32'd1);
        drain();

        // Unmapped access answered by the error port.
        cycle(1'b1, 32'h5000_0000, 1'b1, 4'h0, 1'b1, a);
        chk("req034_acc", 32'(a), 32'd1);
        drain();

        // Outstanding limit: third request stalls until a response returns.
        send(32'h80, 1'b0, 1'b0);
        send(32'h84, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h88, 1'b0, 4'hF, 1'b0, a);
            chk("req035_stall", 32'(a), 32'd0);
        end
        cycle(1'b1, 32'h88, 1'b0, 4'hF, 1'b1, a);
        chk("req035_release", 32'(a), 32'd1);
        drain();

        // Target switch waits for the previous target's response.
        send(32'h80, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h180, 1'b0, 4'hF, 1'b0, a);
            chk("req036_stall", 32'(a), 32'd0);
        end
        cycle(1'b1, 32'h180, 1'b0, 4'hF, 1'b1, a);
        chk("req036_switch", 32'(a), 32'd1);
        drain();

        // Reset with two outstanding, then a late response must be ignored.
        send(32'h80, 1'b0, 1'b0);
        send(32'hFC, 1'b1, 1'b0);
        rst_n = 1'b0;
        mgr_req_i = 1'b0;
        #3;
        chk("rst_mid_req",    32'(sbr_req_o),    32'd0);
        chk("rst_mid_rvalid", 32'(mgr_rvalid_o), 32'd0);
        outst.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        sbr_rvalid_i = 4'b1110;
        #3;
        chk("late_rvalid", 32'(mgr_rvalid_o), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        cycle(1'b1, 32'h180, 1'b0, 4'hF, 1'b1, a);
        chk("post_rst_acc", 32'(a), 32'd1);
        drain();

        // Randomized traffic over rule boundaries and unmapped space.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ad;
            int k;
            k  = $urandom_range(0, 10);
            ad = (k == 10) ? $urandom : atab[k];
            cycle($urandom_range(0, 9) < 7, ad, 1'($urandom), 4'($urandom),
                  1'($urandom), a);
        end
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
